// File: rtl/mem_wait_state_ram_pkg.sv
// Shared constants and types for the wait-state RAM slave.
package mem_pkg;

  localparam int WIDTH      = 16;
  localparam int DEPTH      = 64;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_e;
  typedef logic [WIDTH-1:0] mem_word_t;

  // Wait counter must hold the larger wait count; never narrower than one bit.
  function automatic int cnt_width(input int wr_wait, input int rd_wait);
    int m;
    m = (wr_wait > rd_wait) ? wr_wait : rd_wait;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mem_wait_state_ram_array.sv
// Word storage: async clear, single write port, combinational read port.
module mem_array #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic [WIDTH-1:0]      rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[addr_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/mem_wait_state_ram.sv
// Word-addressed RAM slave with configurable read/write wait states and a
// one-cycle ready_o completion pulse.
//
// state | meaning
// IDLE  | waiting for valid_i; request latched and write committed on accept
// BUSY  | counting down wait states
// RESP  | ready_o high for one cycle, read data already registered
module mem_wait_state_ram
  import mem_pkg::*;
#(
  parameter int WIDTH      = mem_pkg::WIDTH,
  parameter int DEPTH      = mem_pkg::DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int WR_WAIT    = 0,
  parameter int RD_WAIT    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  ready_o
);

  localparam int CW = cnt_width(WR_WAIT, RD_WAIT);
  localparam logic [CW-1:0] WR_CNT = CW'(WR_WAIT);
  localparam logic [CW-1:0] RD_CNT = CW'(RD_WAIT);

  mem_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  is_wr_q, is_wr_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;

  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_rd_data;
  logic [CW-1:0]         load_cnt;

  assign load_cnt = wr_rd_i ? WR_CNT : RD_CNT;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    rd_data_d = rd_data_q;
    mem_wr_en = 1'b0;
    mem_addr  = addr_q;
    case (state_q)
      IDLE: begin
        // The array sees the live address so zero-wait reads resolve at accept.
        mem_addr = addr_i;
        if (valid_i) begin
          addr_d    = addr_i;
          is_wr_d   = wr_rd_i;
          mem_wr_en = wr_rd_i;
          cnt_d     = load_cnt;
          if (load_cnt == '0) begin
            state_d = RESP;
            if (!wr_rd_i) begin
              rd_data_d = mem_rd_data;
            end
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
          if (!is_wr_q) begin
            rd_data_d = mem_rd_data;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      rd_data_q <= rd_data_d;
    end
  end

  mem_array #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (mem_wr_en),
    .addr_i    (mem_addr),
    .wr_data_i (wr_data_i),
    .rd_data_o (mem_rd_data)
  );

  assign ready_o   = (state_q == RESP);
  assign rd_data_o = rd_data_q;

endmodule
